// File: rtl/fetch_queue_stage_pkg.sv
// Shared types and helpers for the instruction fetch queue stage.
// Halfwords are the unit of storage; instructions are one or two halfwords.
package fetch_queue_stage_pkg;

    localparam int         HW_W        = 16;
    localparam logic [6:0] HALT_OPCODE = 7'b1111111;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        compressed;
    } fetch_out_t;

    function automatic logic is_compressed(input logic [HW_W-1:0] hw);
        return hw[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/fetch_queue_stage_halfword_fifo.sv
// Halfword queue with 0/1/2 push and 0/1/2 pop per cycle and a two-entry head peek.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module halfword_fifo
    import fetch_queue_stage_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic [1:0]               push_cnt,
    input  logic [HW_W-1:0]          push_lo,
    input  logic [HW_W-1:0]          push_hi,
    input  logic [1:0]               pop_cnt,
    output logic [$clog2(DEPTH):0]   count,
    output logic [HW_W-1:0]          head,
    output logic [HW_W-1:0]          head_next
);

    localparam int AW = $clog2(DEPTH);

    logic [HW_W-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr_nxt;
    logic [AW-1:0]   rd_ptr_nxt;

    assign wr_ptr_nxt = wr_ptr + AW'(1);
    assign rd_ptr_nxt = rd_ptr + AW'(1);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_cnt);
            rd_ptr <= rd_ptr + AW'(pop_cnt);
            count  <= count + (AW+1)'(push_cnt) - (AW+1)'(pop_cnt);
        end
    end

    // Storage needs no reset; entries are only observed once count covers them.
    always_ff @(posedge clk) begin
        if (!clear) begin
            if (push_cnt != 2'd0) begin
                mem[wr_ptr] <= push_lo;
            end
            if (push_cnt == 2'd2) begin
                mem[wr_ptr_nxt] <= push_hi;
            end
        end
    end

    assign head      = mem[rd_ptr];
    assign head_next = mem[rd_ptr_nxt];

endmodule

// File: rtl/fetch_queue_stage.sv
// Instruction fetch: word reads into a halfword prefetch queue, 16/32-bit extraction
// to decode over valid/ready, redirect flush, halt detection and UART load mode.
module fetch_queue_stage
    import fetch_queue_stage_pkg::*;
#(
    parameter int          QUEUE_DEPTH = 8,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] write_byte_address,
    input  logic [31:0] write_instr_data,
    input  logic        write_instr_valid,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    output logic        imem_we,
    output logic [31:0] imem_wdata,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_compressed,
    output logic        halted
);

    localparam int CW = $clog2(QUEUE_DEPTH);

    logic [31:0]     fetch_addr;
    logic [31:0]     head_pc;
    logic            skip_low;
    logic            inflight;
    logic            epoch;
    logic            resp_epoch;

    logic [CW:0]     count;
    logic [HW_W-1:0] head;
    logic [HW_W-1:0] head_next;
    logic [1:0]      push_cnt;
    logic [1:0]      pop_cnt;
    logic [HW_W-1:0] push_lo;
    logic [HW_W-1:0] push_hi;

    logic            run;
    logic            flush;
    logic            req;
    logic            resp_live;
    logic            head_c;
    logic            extract_ok;
    logic            halt_hit;
    logic            fire;
    logic [CW+1:0]   credit_sum;
    fetch_out_t      cur;

    assign run   = ~rst & start;
    assign flush = ~run | redirect_valid;

    halfword_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push_cnt  (push_cnt),
        .push_lo   (push_lo),
        .push_hi   (push_hi),
        .pop_cnt   (pop_cnt),
        .count     (count),
        .head      (head),
        .head_next (head_next)
    );

    always_comb begin
        head_c         = is_compressed(head);
        cur.pc         = head_pc;
        cur.instr      = head_c ? {16'h0000, head} : {head_next, head};
        cur.compressed = head_c;

        extract_ok = head_c ? (count >= (CW+1)'(1)) : (count >= (CW+1)'(2));
        // The halt word is masked in the cycle it is detected so it is never presented.
        halt_hit   = extract_ok & (cur.instr[6:0] == HALT_OPCODE);
        out_valid  = run & ~redirect_valid & extract_ok & ~halted & ~halt_hit;
        fire       = out_valid & out_ready;
        pop_cnt    = fire ? (head_c ? 2'd1 : 2'd2) : 2'd0;

        // Reserve room for the response already on its way plus the one being asked for.
        credit_sum = {1'b0, count} + (inflight ? (CW+2)'(4) : (CW+2)'(2));
        req        = run & ~halted & ~redirect_valid & (credit_sum <= (CW+2)'(QUEUE_DEPTH));

        resp_live  = inflight & (resp_epoch == epoch) & run & ~redirect_valid;
        push_cnt   = 2'd0;
        push_lo    = imem_rdata[15:0];
        push_hi    = imem_rdata[31:16];
        if (resp_live) begin
            if (skip_low) begin
                push_cnt = 2'd1;
                push_lo  = imem_rdata[31:16];
            end else begin
                push_cnt = 2'd2;
            end
        end

        if (start) begin
            imem_addr  = {fetch_addr[31:2], 2'b00};
            imem_req   = req;
            imem_we    = 1'b0;
            imem_wdata = 32'h0;
        end else begin
            imem_addr  = write_byte_address;
            imem_req   = 1'b0;
            imem_we    = write_instr_valid & ~rst;
            imem_wdata = write_instr_data;
        end
    end

    assign out_pc         = cur.pc;
    assign out_instr      = cur.instr;
    assign out_compressed = cur.compressed;

    always_ff @(posedge clk) begin
        if (!run) begin
            fetch_addr <= RESET_PC;
            head_pc    <= RESET_PC;
            skip_low   <= 1'b0;
            halted     <= 1'b0;
            inflight   <= 1'b0;
            epoch      <= 1'b0;
            resp_epoch <= 1'b0;
        end else if (redirect_valid) begin
            fetch_addr <= {redirect_pc[31:2], 2'b00};
            head_pc    <= redirect_pc;
            skip_low   <= redirect_pc[1];
            halted     <= 1'b0;
            inflight   <= 1'b0;
            // A response tagged with the old epoch can never be pushed after a flush.
            epoch      <= ~epoch;
        end else begin
            inflight <= req;
            if (req) begin
                fetch_addr <= fetch_addr + 32'd4;
                resp_epoch <= epoch;
            end
            if (resp_live) begin
                skip_low <= 1'b0;
            end
            if (halt_hit) begin
                halted <= 1'b1;
            end
            if (fire) begin
                head_pc <= head_pc + (head_c ? 32'd2 : 32'd4);
            end
        end
    end

endmodule
